fetch_arbiter: RTL and testbench

Controller that sequences a byte-wide, synchronous-read program memory to deliver 32-bit instructions, and shares that memory's single port between the instruction-fetch path and a program loader. Sits between the core's fetch stage and the byte-addressed program memory; the memory itself holds one byte per address. A fetch reads four consecutive bytes and packs them big-endian. A loader write is a single-byte store used to fill memory at boot.

---
 rtl/fetch_arbiter_pkg.sv | 19 +
 rtl/fetch_arbiter_instr_byte_packer.sv | 50 +++++
 rtl/fetch_arbiter.sv | 116 +++++++++++
 tb/tb_fetch_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_arbiter_pkg.sv
// Shared types and constants for the fetch arbiter.
//   fa_state_e : controller states (idle, byte reads in flight, last byte return)
//   WORD_BYTES : bytes per instruction word
//   CNT_W      : width of the byte counter that walks one word
//   LAST_BYTE  : counter value of the final byte read of a word
package fetch_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWait
  } fa_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CNT_W      = 2;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_BYTES - 1);

endpackage

// File: rtl/fetch_arbiter_instr_byte_packer.sv
// Collects the bytes of one instruction as they return from memory and
// presents them as a big-endian word.
//   clk, rst_n  : clock, synchronous active-low reset
//   shift_en    : capture byte_in as the next byte of the word being built
//   load        : byte_in is the final byte; publish the completed word
//   byte_in     : memory read data
//   word        : last completed word, first byte in the top lane; holds between loads
//   word_valid  : one-cycle pulse in the cycle after load
module instr_byte_packer
  import fetch_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             shift_en,
  input  logic                             load,
  input  logic [DATA_WIDTH-1:0]            byte_in,
  output logic [WORD_BYTES*DATA_WIDTH-1:0] word,
  output logic                             word_valid
);

  // The final byte goes straight into the output word, so only the leading
  // bytes need to be staged.
  localparam int unsigned StageW = (WORD_BYTES - 1) * DATA_WIDTH;

  logic [StageW-1:0]                stage_q;
  logic [WORD_BYTES*DATA_WIDTH-1:0] word_q;
  logic                             valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= load;
      if (shift_en) begin
        stage_q <= {stage_q[StageW-DATA_WIDTH-1:0], byte_in};
      end
      if (load) begin
        word_q <= {stage_q, byte_in};
      end
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/fetch_arbiter.sv
// Shares a byte-wide, synchronous-read program memory between instruction
// fetch (four-byte big-endian reads) and a boot-time byte loader.
//   clk, rst_n         : clock, synchronous active-low reset
//   fetch_req/fetch_pc : fetch request and byte address, sampled on fetch_gnt
//   fetch_gnt          : combinational, fetch accepted this cycle
//   instr_valid/instr  : registered delivered instruction, valid for one cycle
//   ld_we/ld_addr/ld_data : loader byte write request
//   ld_gnt             : combinational, loader write performed this cycle
//   mem_addr/mem_we/mem_wdata/mem_rdata : memory port, read data one cycle late
module fetch_arbiter
  import fetch_arbiter_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 20,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_req,
  input  logic [ADDRESS_WIDTH-1:0] fetch_pc,
  output logic                     fetch_gnt,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  input  logic                     ld_we,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  output logic                     ld_gnt,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  fa_state_e                state_q;
  logic [CNT_W-1:0]         k_q;
  logic [ADDRESS_WIDTH-1:0] pc_q;

  logic shift_en;
  logic load;

  // Controller state. A started fetch always runs to completion; only reset
  // can abandon it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      pc_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!ld_we && fetch_req) begin
            pc_q    <= fetch_pc;
            k_q     <= '0;
            state_q <= StRead;
          end
        end
        StRead: begin
          k_q <= k_q + CNT_W'(1);
          if (k_q == LAST_BYTE) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          k_q     <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Port mux and grants. The loader has priority in idle.
  always_comb begin
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    shift_en  = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ld_we) begin
          ld_gnt    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ld_addr;
          mem_wdata = ld_data;
        end else if (fetch_req) begin
          fetch_gnt = 1'b1;
        end
      end
      StRead: begin
        // Address wraps modulo the memory size by plain truncation.
        mem_addr = pc_q + ADDRESS_WIDTH'(k_q);
        // Read data lags the address by one cycle: at k>0 it holds byte k-1.
        shift_en = (k_q != '0);
      end
      StWait: begin
        load = 1'b1;
      end
      default: ;
    endcase
  end

  instr_byte_packer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (shift_en),
    .load      (load),
    .byte_in   (mem_rdata),
    .word      (instr),
    .word_valid(instr_valid)
  );

endmodule

// File: tb/tb_fetch_arbiter.sv
module tb_fetch_arbiter;

  localparam int unsigned AW = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req;
  logic [AW-1:0] fetch_pc;
  logic          fetch_gnt;
  logic          instr_valid;
  logic [31:0]   instr;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  logic          ld_gnt;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_arbiter #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_pc   (fetch_pc),
    .fetch_gnt  (fetch_gnt),
    .instr_valid(instr_valid),
    .instr      (instr),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_gnt     (ld_gnt),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Synchronous-read byte memory model.
  logic [7:0] mem [0:(1 << AW) - 1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One complete fetch: waits (bounded) for the grant, then checks the
  // address sequence, the 6-cycle latency, the one-cycle pulse and the hold.
  task automatic do_fetch(input logic [AW-1:0] pc, input logic [31:0] exp, input string nm);
    int            w;
    logic [AW-1:0] ea;
    w = 0;
    @(negedge clk);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    ld_we     = 1'b0;
    #1;
    while (!fetch_gnt && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk({nm, " grant"}, 32'(fetch_gnt), 32'd1);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      fetch_req = 1'b0;
      #1;
      if (i <= 4) begin
        ea = pc + AW'(i - 1);
        chk({nm, " mem_addr"}, 32'(mem_addr), 32'(ea));
        chk({nm, " mem_we"}, 32'(mem_we), 32'd0);
      end
      if (i < 6) begin
        chk({nm, " early valid"}, 32'(instr_valid), 32'd0);
      end else if (i == 6) begin
        chk({nm, " valid"}, 32'(instr_valid), 32'd1);
        chk({nm, " instr"}, instr, exp);
      end else begin
        chk({nm, " valid drop"}, 32'(instr_valid), 32'd0);
        chk({nm, " instr hold"}, instr, exp);
      end
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } ld_vec_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   exp;
    string         nm;
  } fetch_vec_t;

  ld_vec_t    loads   [14];
  fetch_vec_t fetches [3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int g [3];
    int ng;
    int nv;
    int seen;

    loads[0]  = '{20'h00000, 8'h11};
    loads[1]  = '{20'h00001, 8'h22};
    loads[2]  = '{20'h00002, 8'h33};
    loads[3]  = '{20'h00003, 8'h44};
    loads[4]  = '{20'h00100, 8'hAA};
    loads[5]  = '{20'h00101, 8'hBB};
    loads[6]  = '{20'h00102, 8'hCC};
    loads[7]  = '{20'h00103, 8'hDD};
    loads[8]  = '{20'h00005, 8'h55};
    loads[9]  = '{20'h00006, 8'h66};
    loads[10] = '{20'h00007, 8'h77};
    loads[11] = '{20'h00008, 8'h88};
    loads[12] = '{20'hFFFFE, 8'h01};
    loads[13] = '{20'hFFFFF, 8'h02};

    fetches[0] = '{20'h00000, 32'h11223344, "fetch0"};
    fetches[1] = '{20'h00100, 32'hAABBCCDD, "fetch100"};
    fetches[2] = '{20'h00005, 32'h55667788, "fetch_unaligned"};

    rst_n     = 1'b0;
    fetch_req = 1'b0;
    fetch_pc  = '0;
    ld_we     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset instr_valid", 32'(instr_valid), 32'd0);
    chk("reset instr", instr, 32'h0);
    chk("reset fetch_gnt", 32'(fetch_gnt), 32'd0);
    chk("reset ld_gnt", 32'(ld_gnt), 32'd0);
    chk("idle mem_addr", 32'(mem_addr), 32'd0);
    chk("idle mem_we", 32'(mem_we), 32'd0);
    chk("idle mem_wdata", 32'(mem_wdata), 32'd0);

    // Back-to-back loader writes, one per cycle.
    foreach (loads[i]) begin
      @(negedge clk);
      ld_we   = 1'b1;
      ld_addr = loads[i].addr;
      ld_data = loads[i].data;
      #1;
      chk("load ld_gnt", 32'(ld_gnt), 32'd1);
      chk("load mem_we", 32'(mem_we), 32'd1);
      chk("load mem_addr", 32'(mem_addr), 32'(loads[i].addr));
      chk("load mem_wdata", 32'(mem_wdata), 32'(loads[i].data));
    end
    @(negedge clk);
    ld_we = 1'b0;
    #1;
    chk("load release ld_gnt", 32'(ld_gnt), 32'd0);

    foreach (fetches[i]) begin
      do_fetch(fetches[i].pc, fetches[i].exp, fetches[i].nm);
    end

    // Loader and fetch together: loader first, fetch on the next idle cycle,
    // loader locked out for the whole fetch.
    @(negedge clk);
    ld_we     = 1'b1;
    ld_addr   = 20'h00200;
    ld_data   = 8'h5A;
    fetch_req = 1'b1;
    fetch_pc  = 20'h00100;
    #1;
    chk("simul ld_gnt", 32'(ld_gnt), 32'd1);
    chk("simul fetch_gnt", 32'(fetch_gnt), 32'd0);
    @(negedge clk);
    ld_we = 1'b0;
    #1;
    chk("after ld fetch_gnt", 32'(fetch_gnt), 32'd1);
    chk("after ld ld_gnt", 32'(ld_gnt), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      fetch_req = 1'b0;
      ld_we     = 1'b1;
      ld_addr   = 20'h00201;
      ld_data   = 8'h6B;
      #1;
      if (i < 6) begin
        chk("busy ld_gnt", 32'(ld_gnt), 32'd0);
        chk("busy mem_we", 32'(mem_we), 32'd0);
        chk("busy fetch_gnt", 32'(fetch_gnt), 32'd0);
      end else begin
        chk("idle ld_gnt", 32'(ld_gnt), 32'd1);
        chk("simul valid", 32'(instr_valid), 32'd1);
        chk("simul instr", instr, 32'hAABBCCDD);
      end
    end
    @(negedge clk);
    ld_we = 1'b0;

    // Reset in the middle of a fetch.
    @(negedge clk);
    fetch_req = 1'b1;
    fetch_pc  = 20'h00100;
    #1;
    chk("midrst grant", 32'(fetch_gnt), 32'd1);
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst instr", instr, 32'h0);
    chk("midrst valid", 32'(instr_valid), 32'd0);
    chk("midrst mem_addr", 32'(mem_addr), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (instr_valid) seen++;
    end
    chk("midrst no valid", 32'(seen), 32'd0);
    do_fetch(20'h00005, 32'h55667788, "post_reset");

    // fetch_req held: grants every 6 cycles, each overlapping a delivery.
    ng = 0;
    nv = 0;
    @(negedge clk);
    fetch_req = 1'b1;
    fetch_pc  = 20'h00100;
    for (int c = 0; c < 13; c++) begin
      #1;
      if (fetch_gnt && ng < 3) begin
        g[ng] = c;
        ng++;
      end
      if (instr_valid) begin
        nv++;
        chk("b2b instr", instr, 32'hAABBCCDD);
      end
      @(negedge clk);
    end
    fetch_req = 1'b0;
    repeat (8) @(negedge clk);
    chk("b2b grants", 32'(ng), 32'd3);
    chk("b2b valids", 32'(nv), 32'd2);
    if (ng == 3) begin
      chk("b2b gap1", 32'(g[1] - g[0]), 32'd6);
      chk("b2b gap2", 32'(g[2] - g[1]), 32'd6);
    end

    // Address wrap past the top of memory.
    @(negedge clk);
    ld_we   = 1'b1;
    ld_addr = 20'h00000;
    ld_data = 8'h03;
    @(negedge clk);
    ld_addr = 20'h00001;
    ld_data = 8'h04;
    @(negedge clk);
    ld_we = 1'b0;
    do_fetch(20'hFFFFE, 32'h01020304, "wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
